// File: rtl/tetris_pkg.sv
// Shared register map, FSM state type and guard classification for the Tetris command arbiter.
package tetris_pkg;

   localparam logic [7:0] REG_BLOCK  = 8'd0;
   localparam logic [7:0] REG_DELROW = 8'd1;
   localparam logic [7:0] REG_SCORE  = 8'd2;
   localparam logic [7:0] REG_NEXT   = 8'd3;
   localparam logic [7:0] REG_SPEED  = 8'd4;
   localparam logic [7:0] REG_RESET  = 8'd5;
   localparam logic [7:0] REG_PAUSE  = 8'd6;

   localparam int unsigned GUARD_CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GUARD = 2'd2
   } state_t;

   // Writes whose side effect the peripheral applies one cycle late.
   function automatic logic is_guarded(input logic [7:0] addr);
      return (addr == REG_BLOCK) || (addr == REG_DELROW) || (addr == REG_RESET);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant_c,
   output logic [PTR_W-1:0]   o_grant_idx_c,
   output logic               o_any_c
);

   logic [PTR_W-1:0] w_idx;

   function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                 input int unsigned      off);
      int unsigned v;
      v = 32'(base) + off;
      if (v >= NUM_REQ) v = v - NUM_REQ;
      return PTR_W'(v);
   endfunction

   always_comb begin
      o_grant_c     = '0;
      o_grant_idx_c = '0;
      o_any_c       = 1'b0;
      w_idx         = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         w_idx = wrap_idx(i_ptr, off);
         if (!o_any_c && i_req[w_idx]) begin
            o_any_c          = 1'b1;
            o_grant_idx_c    = w_idx;
            o_grant_c[w_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tetris_cmd_arbiter.sv
// Shares the peripheral register-write port among NUM_REQ sources with guard gaps.
// Optional macro TETRIS_ARB_STRICT0_EN gives requester 0 strict priority.
module tetris_cmd_arbiter
   import tetris_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 3,
   parameter int unsigned ADDR_W       = 3,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned GUARD_CYCLES = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]     req_data,
   output logic                          av_chipselect,
   output logic                          av_write,
   output logic [ADDR_W-1:0]             av_address,
   output logic [DATA_W-1:0]             av_writedata,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   state_t                 r_state, w_state_nxt;
   logic [GUARD_CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [ID_W-1:0]        r_ptr, r_gid, w_gidx, w_rr_idx, w_ptr_inc;
   logic [ADDR_W-1:0]      r_addr, w_sel_addr;
   logic [DATA_W-1:0]      r_data, w_sel_data;
   logic                   r_av_cs, r_busy;
   logic                   w_grant_en, w_any, w_ptr_upd;
   logic [NUM_REQ-1:0]     w_grant, w_rr_grant;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (ID_W)
   ) u_rr (
      .i_req         (req_valid),
      .i_ptr         (r_ptr),
      .o_grant_c     (w_rr_grant),
      .o_grant_idx_c (w_rr_idx),
      .o_any_c       (w_any)
   );

`ifdef TETRIS_ARB_STRICT0_EN
   // Requester 0 overrides the rotation and leaves the pointer untouched.
   always_comb begin
      w_grant   = w_rr_grant;
      w_gidx    = w_rr_idx;
      w_ptr_upd = 1'b1;
      if (req_valid[0]) begin
         w_grant   = NUM_REQ'(1);
         w_gidx    = '0;
         w_ptr_upd = 1'b0;
      end
   end
`else
   assign w_grant   = w_rr_grant;
   assign w_gidx    = w_rr_idx;
   assign w_ptr_upd = 1'b1;
`endif

   // Payload mux for the granted requester.
   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign w_ptr_inc = (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + ID_W'(1);

   // Next state; a one-cycle guard is fully covered by the IDLE re-grant cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_grant_en  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_grant_en  = 1'b1;
               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (is_guarded(8'(r_addr))) begin
               if (GUARD_CYCLES > 1) begin
                  w_state_nxt = GUARD;
                  w_cnt_nxt   = GUARD_CNT_W'(GUARD_CYCLES);
               end else begin
                  w_state_nxt = IDLE;
               end
            end else if (w_any) begin
               w_grant_en  = 1'b1;
               w_state_nxt = ISSUE;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         GUARD: begin
            w_cnt_nxt = r_cnt - GUARD_CNT_W'(1);
            if (r_cnt <= GUARD_CNT_W'(2)) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_gid   <= '0;
         r_av_cs <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_av_cs <= w_grant_en;
         r_busy  <= (w_state_nxt != IDLE);
         if (w_grant_en) begin
            r_addr <= w_sel_addr;
            r_data <= w_sel_data;
            r_gid  <= w_gidx;
            if (w_ptr_upd) r_ptr <= w_ptr_inc;
         end
      end
   end

   assign req_ready     = (w_grant_en && !reset) ? w_grant : '0;
   assign av_chipselect = r_av_cs;
   assign av_write      = r_av_cs;
   assign av_address    = r_addr;
   assign av_writedata  = r_data;
   assign grant_id      = r_gid;
   assign busy          = r_busy;

endmodule
